// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: immediate-format codes, opcodes and the
// fetch FSM state encoding.
package riscv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_J = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_e;

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode predecode: immediate-format select plus unknown-opcode flag.
module imm_src_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src,
  output logic       illegal
);

  always_comb begin
    imm_src = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm_src = IMM_I;
      OP_STORE:                 imm_src = IMM_S;
      OP_JAL:                   imm_src = IMM_J;
      OP_BRANCH:                imm_src = IMM_B;
      OP_LUI, OP_AUIPC:         imm_src = IMM_U;
      OP_REG:                   imm_src = IMM_I;
      default:                  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch stage with redirect handling.
// Optional opcode predecode is enabled with `define FETCH_PREDECODE_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [2:0]  imm_src,
  output logic        illegal
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0]  instr_q, instr_d, id_pc_q, id_pc_d, pc4_q, pc4_d;
  logic         req_q, req_d, valid_q, valid_d;
  logic         capture;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    req_d   = req_q;
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    pc4_d   = pc4_q;
    capture = 1'b0;
    case (state_q)
      FETCH: begin
        // req_q low here only in the cycle after reset: nothing is outstanding yet
        if (!req_q) begin
          req_d = 1'b1;
          if (redirect) pc_d = redirect_pc;
        end else if (redirect) begin
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = DROP;
          end
        end else if (imem_ack) begin
          capture = 1'b1;
          instr_d = imem_rdata;
          id_pc_d = pc_q;
          pc4_d   = pc_q + 32'd4;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect || id_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
          if (redirect) pc_d = redirect_pc;
        end
      end
      DROP: begin
        // the old request must complete before the new address goes out
        if (redirect) tgt_d = redirect_pc;
        if (imem_ack) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      id_pc_q <= 32'd0;
      pc4_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      pc4_q   <= pc4_d;
    end
  end

`ifdef FETCH_PREDECODE_EN
  logic [2:0] dec_imm;
  logic       dec_ill;
  logic [2:0] imm_src_q, imm_src_d;
  logic       illegal_q, illegal_d;

  imm_src_decoder u_dec (
    .opcode  (imem_rdata[6:0]),
    .imm_src (dec_imm),
    .illegal (dec_ill)
  );

  always_comb begin
    imm_src_d = capture ? dec_imm : imm_src_q;
    illegal_d = capture ? dec_ill : illegal_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_src_q <= IMM_I;
      illegal_q <= 1'b0;
    end else begin
      imm_src_q <= imm_src_d;
      illegal_q <= illegal_d;
    end
  end

  assign imm_src = imm_src_q;
  assign illegal = illegal_q;
`else
  assign imm_src = IMM_I;
  assign illegal = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: transaction-level model compared every cycle,
// plus hand-computed literal checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, imem_ack, redirect, id_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, id_valid, illegal;
  logic [31:0] imem_addr, id_instr, id_pc, id_pc_plus4;
  logic [2:0]  imm_src;

  int n_chk = 0;
  int n_pass = 0;

  fetch_stage #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .imm_src(imm_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Model: what fetch must have done given the rules, as plain variables
  logic        m_req, m_valid, m_drop, m_ill;
  logic [31:0] m_pc, m_tgt, m_instr, m_idpc, m_pc4;
  logic [2:0]  m_imm;

  function automatic logic [3:0] predecode(input logic [6:0] op);
`ifdef FETCH_PREDECODE_EN
    case (op)
      7'h13, 7'h03, 7'h67: return 4'b000_0;
      7'h23:               return 4'b001_0;
      7'h6F:               return 4'b010_0;
      7'h63:               return 4'b011_0;
      7'h37, 7'h17:        return 4'b100_0;
      7'h33:               return 4'b000_0;
      default:             return 4'b000_1;
    endcase
`else
    return {3'b000, 1'b0} | {4{op == 7'h80}};
`endif
  endfunction

  task automatic model_update();
    if (rst) begin
      m_pc = 32'h100; m_req = 0; m_valid = 0; m_drop = 0; m_tgt = 0;
      m_instr = 0; m_idpc = 0; m_pc4 = 0; m_imm = 0; m_ill = 0;
    end else if (m_valid) begin
      if (redirect) begin m_valid = 0; m_req = 1; m_pc = redirect_pc; end
      else if (id_ready) begin m_valid = 0; m_req = 1; end
    end else if (!m_req) begin
      m_req = 1;
      if (redirect) m_pc = redirect_pc;
    end else if (m_drop) begin
      if (redirect) m_tgt = redirect_pc;
      if (imem_ack) begin m_pc = m_tgt; m_drop = 0; end
    end else if (redirect) begin
      if (imem_ack) m_pc = redirect_pc;
      else begin m_drop = 1; m_tgt = redirect_pc; end
    end else if (imem_ack) begin
      m_instr = imem_rdata; m_idpc = m_pc; m_pc4 = m_pc + 32'd4;
      {m_imm, m_ill} = predecode(imem_rdata[6:0]);
      m_pc = m_pc + 32'd4; m_valid = 1; m_req = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare();
    logic [133:0] a, e;
    a = {imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, imm_src, illegal};
    e = {m_req, m_pc, m_valid, m_instr, m_idpc, m_pc4, m_imm, m_ill};
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL model_cycle @%0t: got %h expected %h", $time, a, e);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  logic [6:0] ops [8]  = '{7'h23, 7'h6F, 7'h63, 7'h37, 7'h7F, 7'h13, 7'h33, 7'h17};
`ifdef FETCH_PREDECODE_EN
  logic [2:0] eimm [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd4};
  logic       eill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  logic [2:0] eimm [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic       eill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    rst = 1; imem_ack = 0; redirect = 0; id_ready = 0; imem_rdata = 0; redirect_pc = 0;
    step();
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 0;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'h100);

    rst = 0;
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 0;
    chk("addi_pc", id_pc, 32'h100);
    chk("addi_pc4", id_pc_plus4, 32'h104);
    chk("addi_imm", {29'd0, imm_src}, 32'd0);
    chk("addi_ill", {31'd0, illegal}, 32'd0);
    chk("addi_valid", {31'd0, id_valid}, 32'd1);
    chk("addi_next_addr", imem_addr, 32'h104);

    repeat (5) step();
    chk("stall_valid", {31'd0, id_valid}, 32'd1);
    chk("stall_instr", id_instr, 32'h0050_0093);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    id_ready = 1;
    step();
    id_ready = 0;
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h104);

    imem_ack = 1; imem_rdata = 32'h0000_0023;
    step();
    imem_ack = 0;
    redirect = 1; redirect_pc = 32'h200; id_ready = 1;
    step();
    redirect = 0; id_ready = 0;
    chk("hold_redir_valid", {31'd0, id_valid}, 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h200);

    redirect = 1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect = 0;
    step();
    chk("drop_old_addr", imem_addr, 32'h200);
    imem_ack = 1; imem_rdata = 32'h0000_006F;
    step();
    imem_ack = 0;
    chk("drop_addr", imem_addr, 32'h400);
    chk("drop_discard", {31'd0, id_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      imem_ack = 1; imem_rdata = 32'h0ABC_D000 | {25'd0, ops[i]};
      step();
      imem_ack = 0;
      chk($sformatf("op%02h_imm", ops[i]), {29'd0, imm_src}, {29'd0, eimm[i]});
      chk($sformatf("op%02h_ill", ops[i]), {31'd0, illegal}, {31'd0, eill[i]});
      id_ready = 1;
      step();
      id_ready = 0;
    end

    redirect = 1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1;
    step();
    redirect = 0;
    chk("redir_ack_addr", imem_addr, 32'hFFFF_FFFC);
    chk("redir_ack_valid", {31'd0, id_valid}, 32'd0);
    imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 0;
    chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", id_pc_plus4, 32'd0);
    id_ready = 1;
    step();
    id_ready = 0;
    chk("wrap_addr", imem_addr, 32'd0);

    redirect = 1; redirect_pc = 32'h700;
    step();
    redirect = 0;
    rst = 1;
    step();
    rst = 0;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_addr", imem_addr, 32'h100);
    imem_ack = 1; imem_rdata = 32'h0000_0033;
    step();
    imem_ack = 0;
    chk("midrst_valid", {31'd0, id_valid}, 32'd0);
    imem_ack = 1;
    step();
    imem_ack = 0;
    chk("midrst_fetch_pc", id_pc, 32'h100);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
